// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use bubbles, branch flushes and memory-wait freezes for the 5-stage pipe
module hazard_stall_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_adress,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [3:0] FRELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WMAX    = 8'(MEM_TIMEOUT);

    state_t     cur, nxt;
    logic [3:0] fcnt, fcnt_n;
    logic [7:0] wcnt, wcnt_n;
    logic       to_n, load_use, mem_stall;

    assign load_use  = ex_mem_read && ex_write_adress != 5'd0 &&
                       (ex_write_adress == id_rs || (id_uses_rt && ex_write_adress == id_rt));
    assign mem_stall = mem_req && !mem_ready;
    assign state     = cur;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        nxt         = cur;
        fcnt_n      = fcnt;
        wcnt_n      = wcnt;
        to_n        = mem_timeout;
        case (cur)
            RUN: begin
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    nxt         = MEM_WAIT;
                    wcnt_n      = 8'd1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        nxt    = FLUSH;
                        fcnt_n = FRELOAD;
                    end
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    nxt    = RUN;
                    wcnt_n = 8'd0;
                end else begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    if (wcnt == WMAX) begin
                        nxt    = RUN;
                        wcnt_n = 8'd0;
                        to_n   = 1'b1;
                    end else begin
                        wcnt_n = wcnt + 8'd1;
                    end
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    nxt         = MEM_WAIT;
                    wcnt_n      = 8'd1;
                    fcnt_n      = 4'd0;
                end else begin
                    ifid_flush = 1'b1;
                    if (branch_taken) begin
                        fcnt_n = FRELOAD;
                    end else begin
                        fcnt_n = fcnt - 4'd1;
                        if (fcnt == 4'd1) nxt = RUN;
                    end
                end
            end
            default: nxt = RUN;
        endcase
        // while held in reset the pipe sees plain defaults whatever the inputs
        if (!rst) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur          <= RUN;
            fcnt         <= 4'd0;
            wcnt         <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            cur         <= nxt;
            fcnt        <= fcnt_n;
            wcnt        <= wcnt_n;
            mem_timeout <= to_n;
            if (!pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; companion to the EX-stage forwarding logic.
- Resolves the hazards forwarding cannot cover: load-use stalls, taken-branch flushes of IF/ID, and freezes the whole pipe while a multi-cycle data-memory access is outstanding.
- Drives PC/IF-ID write enables, flush and bubble controls; keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed per taken branch (1..15).
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before a timeout is declared (1..255).
- CNT_W, 16, width of stall_cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_write_adress  in  5  destination register of instruction in EX.
- branch_taken  in  1  branch/jump resolved taken this cycle.
- mem_req  in  1  instruction in MEM is accessing data memory.
- mem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  zero ID/EX control signals.
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.
- state  out  2  current FSM state (RUN=0, MEM_WAIT=1, FLUSH=2).

Behaviour:
- Defaults every cycle: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0. Outputs are combinational from state + inputs (Mealy); state, counters and flags are registered.
- Reset (rst=0, async): state=RUN, flush counter=0, wait counter=0, mem_timeout=0, stall_cycles=0; control outputs held at defaults regardless of inputs.
- load_use = ex_mem_read && ex_write_adress!=0 && (ex_write_adress==id_rs || (id_uses_rt && ex_write_adress==id_rt)).
- Priority per cycle: memory wait > branch flush > load-use.
- RUN:
  - mem_req && !mem_ready: pipe_freeze=1, pc_write=0, ifid_write=0 this cycle; next state MEM_WAIT, wait counter=1.
  - else branch_taken: ifid_flush=1; if FLUSH_CYCLES>1, next state FLUSH with flush counter=FLUSH_CYCLES-1; else stay RUN.
  - else load_use: pc_write=0, ifid_write=0, idex_bubble=1; stay RUN (single-cycle bubble; hazard clears once the load advances).
  - mem_req && mem_ready in the same cycle: no freeze (zero-wait access).
- MEM_WAIT:
  - pipe_freeze=1, pc_write=0, ifid_write=0; branch_taken and load_use ignored (pipe frozen, re-evaluated after release).
  - mem_ready=1: outputs return to defaults that cycle (pipe advances); next state RUN, wait counter cleared.
  - wait counter==MEM_TIMEOUT and !mem_ready: next state RUN, mem_timeout set to 1 (sticky until reset). If mem_req is still high in RUN, MEM_WAIT is re-entered.
  - Otherwise the wait counter increments.
- FLUSH:
  - ifid_flush=1, pc_write=1.
  - mem_req && !mem_ready takes priority: freeze as in RUN, go MEM_WAIT, remaining flush count discarded.
  - New branch_taken reloads the flush counter to FLUSH_CYCLES-1.
  - Otherwise decrement; when the counter reaches 0 (after decrement), go to RUN.
- stall_cycles increments on every cycle with pc_write=0 outside reset; saturates at all-ones (no wrap).
- Register 0 never causes a load-use stall.

Test Plan:
- Reset: rst low mid-MEM_WAIT -> immediately state=0, pipe_freeze=0, pc_write=1, stall_cycles=0, mem_timeout=0.
- Load-use: ex_mem_read=1, ex_write_adress=5, id_rs=5 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1. Same with ex_write_adress=0 -> no stall.
- rt check: ex_write_adress=7, id_rt=7, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> pipe_freeze=1 for 3 cycles, state=1, deasserted in the ready cycle, stall_cycles=3. Branch_taken during the wait -> no ifid_flush.
- Timeout: MEM_TIMEOUT=4, mem_ready never asserted -> mem_timeout=1 after the 4th wait cycle, state back to RUN, flag stays set.
- Flush: FLUSH_CYCLES=3, branch_taken pulse -> ifid_flush=1 for 3 cycles, pc_write=1 throughout. Branch_taken together with load_use -> flush only, no bubble. CNT_W=2 with 5 stall cycles -> stall_cycles=3.
